// File: rtl/cl_frame_capture_ctrl_if.sv
// Capture-controller signal bundle: CL words, run control and config in; gated CL words and run status out.
// slave = the capture controller, master = deserializer/software side driving it.
interface cl_frame_capture_ctrl_if #(
    parameter int C_CNT_WIDTH = 16
);
    logic [27:0]            CL_DATA;
    logic                   start;
    logic                   stop;
    logic [C_CNT_WIDTH-1:0] cfg_num_frames;
    logic [C_CNT_WIDTH-1:0] cfg_width;
    logic [27:0]            CL_DATA_O;
    logic                   capture_en;
    logic                   pix_valid;
    logic                   sof;
    logic                   eol;
    logic                   busy;
    logic                   done;
    logic [C_CNT_WIDTH-1:0] frame_count;
    logic [C_CNT_WIDTH-1:0] line_count;
    logic                   err_line_len;

    modport slave (
        input  CL_DATA, start, stop, cfg_num_frames, cfg_width,
        output CL_DATA_O, capture_en, pix_valid, sof, eol, busy, done,
               frame_count, line_count, err_line_len
    );

    modport master (
        output CL_DATA, start, stop, cfg_num_frames, cfg_width,
        input  CL_DATA_O, capture_en, pix_valid, sof, eol, busy, done,
               frame_count, line_count, err_line_len
    );
endinterface

// File: rtl/cl_frame_capture_ctrl.sv
// Camera Link frame-capture sequencer: gates whole frames only, counts frames/lines/pixels, flags bad line lengths.
// Two-cycle latency; every output is registered and aligned with CL_DATA_O. No backpressure: the CL stream is free-running.
module cl_frame_capture_ctrl #(
    parameter int C_CNT_WIDTH = 16
) (
    input  logic                   M_AXIS_ACLK,
    input  logic                   M_AXIS_ARESETN,
    cl_frame_capture_ctrl_if.slave cl
);
    localparam int CW = C_CNT_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT_GAP, WAIT_SOF, CAPTURE} state_t;

    state_t        state, state_nxt;
    logic [27:0]   q1, q2;
    logic [CW-1:0] nf_r, width_r, pix_cnt, frame_cnt, line_cnt, frame_inc;
    logic          stop_pend, cap_r, sof_r, eol_r, pv_r, done_r, busy_r, err_r;
    logic          f1, f2, l1, l2, d1;
    logic          fval_rise, fval_fall, lval_rise, lval_fall;
    logic          start_ok, frame_last, frame_end, line_end;
    logic          cap_nxt, sof_nxt, done_nxt, pv_nxt;

    // Edges are taken between the two pipeline stages so decisions land exactly on the q2 word.
    assign f1 = q1[26];
    assign l1 = q1[25];
    assign d1 = q1[24];
    assign f2 = q2[26];
    assign l2 = q2[25];
    assign fval_rise = f1 & ~f2;
    assign fval_fall = ~f1 & f2;
    assign lval_rise = l1 & ~l2;
    assign lval_fall = ~l1 & l2;

    assign start_ok   = (state == IDLE) && cl.start && !cl.stop;
    assign frame_inc  = frame_cnt + 1'b1;
    assign frame_last = ((nf_r != '0) && (frame_inc == nf_r)) || stop_pend || cl.stop;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) state <= IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok) state_nxt = WAIT_GAP;
            WAIT_GAP: if (cl.stop) state_nxt = IDLE;
                      else if (!f1) state_nxt = WAIT_SOF;
            WAIT_SOF: if (cl.stop) state_nxt = IDLE;
                      else if (fval_rise) state_nxt = CAPTURE;
            CAPTURE:  if (fval_fall) state_nxt = frame_last ? IDLE : WAIT_SOF;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_nxt   = (state_nxt == CAPTURE);
        sof_nxt   = (state != CAPTURE) && (state_nxt == CAPTURE);
        done_nxt  = (state != IDLE) && (state_nxt == IDLE);
        pv_nxt    = cap_nxt && l1 && d1;
        frame_end = (state == CAPTURE) && fval_fall;
        // A line still open when FVAL drops is closed as a truncated line.
        line_end  = (state == CAPTURE) && (lval_fall || (fval_fall && l1));
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            q1        <= '0;
            q2        <= '0;
            cap_r     <= 1'b0;
            sof_r     <= 1'b0;
            eol_r     <= 1'b0;
            pv_r      <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            stop_pend <= 1'b0;
            nf_r      <= '0;
            width_r   <= '0;
            pix_cnt   <= '0;
            frame_cnt <= '0;
            line_cnt  <= '0;
        end else begin
            q1     <= cl.CL_DATA;
            q2     <= q1;
            cap_r  <= cap_nxt;
            sof_r  <= sof_nxt;
            eol_r  <= line_end;
            pv_r   <= pv_nxt;
            done_r <= done_nxt;
            busy_r <= (state_nxt != IDLE);

            if (lval_rise)   pix_cnt <= pv_nxt ? CW'(1) : '0;
            else if (pv_nxt) pix_cnt <= pix_cnt + 1'b1;

            if (start_ok) begin
                nf_r      <= cl.cfg_num_frames;
                width_r   <= cl.cfg_width;
                frame_cnt <= '0;
                line_cnt  <= '0;
                err_r     <= 1'b0;
                stop_pend <= 1'b0;
            end else begin
                if (done_nxt)                            stop_pend <= 1'b0;
                else if ((state == CAPTURE) && cl.stop)  stop_pend <= 1'b1;
                if (frame_end) frame_cnt <= frame_inc;
                if (sof_nxt)       line_cnt <= '0;
                else if (line_end) line_cnt <= line_cnt + 1'b1;
                if (line_end && (pix_cnt != width_r)) err_r <= 1'b1;
            end
        end
    end

    assign cl.CL_DATA_O    = q2;
    assign cl.capture_en   = cap_r;
    assign cl.pix_valid    = pv_r;
    assign cl.sof          = sof_r;
    assign cl.eol          = eol_r;
    assign cl.busy         = busy_r;
    assign cl.done         = done_r;
    assign cl.frame_count  = frame_cnt;
    assign cl.line_count   = line_cnt;
    assign cl.err_line_len = err_r;
endmodule
